// File: rtl/rx_engine_pkg.sv
// Shared definitions for the rx_engine UART receiver: FSM encoding,
// default bit-time width and the frame register length.
package rx_engine_pkg;

  localparam int KW_DEFAULT = 20;
  localparam int FRAME_LEN  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_engine_if.sv
// Host-side bundle of the rx_engine: line configuration, serial input and
// the received-frame outputs.
interface rx_engine_if #(parameter int KW = rx_engine_pkg::KW_DEFAULT);

  logic [KW-1:0] K;
  logic          EIGHT;
  logic          PEN;
  logic          OHEL;
  logic          RX_in;
  // RXRDY acts as valid for UART_DATA/PERR/FERR; a one-cycle READS pulse is
  // the consume strobe and drops RXRDY (and OVF) on the following edge.
  logic          READS;
  logic          RXRDY;
  logic [7:0]    UART_DATA;
  logic          PERR;
  logic          FERR;
  logic          OVF;

  modport master (
    output K, EIGHT, PEN, OHEL, RX_in, READS,
    input  RXRDY, UART_DATA, PERR, FERR, OVF
  );

  modport slave (
    input  K, EIGHT, PEN, OHEL, RX_in, READS,
    output RXRDY, UART_DATA, PERR, FERR, OVF
  );

endinterface

// File: rtl/rx_engine_bittime.sv
// Bit-time counter: ticks for one cycle after K (or K>>1 when half-select
// is set) enabled cycles, then restarts from zero.
module rx_bittime
  import rx_engine_pkg::*;
#(
  parameter int KW = KW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic [KW-1:0] i_k,
  input  logic          i_half,
  output logic          o_tick
);

  logic [KW-1:0] r_cnt;
  logic [KW-1:0] w_last;

  assign w_last = (i_half ? (i_k >> 1) : i_k) - KW'(1);
  assign o_tick = i_enable && (r_cnt == w_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + KW'(1);
    end
  end

endmodule

// File: rtl/rx_engine.sv
// UART receive engine: start-bit qualification, mid-bit sampling, parity
// and framing checks. Define RX_SYNC_EN to add a two-flop input synchronizer.
module rx_engine
  import rx_engine_pkg::*;
#(
  parameter int KW = KW_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  rx_engine_if.slave bus,
  output rx_state_t o_state
);

  rx_state_t r_state;
  rx_state_t w_next;
  logic      w_rx;
  logic      w_tick;
  logic      w_clear;
  logic      w_enable;
  logic      w_half;
  logic      w_shift;
  logic      w_done;

  logic [FRAME_LEN-1:0] r_frame;
  logic [3:0]           r_nsamp;
  logic [3:0]           w_n;
  logic [FRAME_LEN-1:0] w_aligned;
  logic [7:0]           w_data;
  logic                 w_par_bit;
  logic                 w_stop;
  logic                 w_perr;

  logic       r_rxrdy;
  logic [7:0] r_data;
  logic       r_perr;
  logic       r_ferr;
  logic       r_ovf;

`ifdef RX_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], bus.RX_in};
  end
  assign w_rx = r_sync[1];
`else
  assign w_rx = bus.RX_in;
`endif

  rx_bittime #(.KW(KW)) u_bittime (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .i_k      (bus.K),
    .i_half   (w_half),
    .o_tick   (w_tick)
  );

  // Samples per frame: data bits, optional parity, then stop.
  assign w_n = 4'd8 + {3'b000, bus.EIGHT} + {3'b000, bus.PEN};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_rx) w_next = START;
      START:   if (w_tick) w_next = w_rx ? IDLE : DATA;
      DATA:    if (w_tick && (r_nsamp == w_n - 4'd1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_clear  = (r_state == IDLE) || (r_state == DONE);
    w_enable = (r_state == START) || (r_state == DATA);
    w_half   = (r_state == START);
    w_shift  = (r_state == DATA) && w_tick;
    w_done   = (r_state == DONE);
  end

  // Samples enter at the top so the frame ends up right-justified after a shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame <= '0;
      r_nsamp <= '0;
    end else begin
      if (w_shift) r_frame <= {w_rx, r_frame[FRAME_LEN-1:1]};
      if (r_state != DATA) r_nsamp <= '0;
      else if (w_shift)    r_nsamp <= r_nsamp + 4'd1;
    end
  end

  assign w_aligned = r_frame >> (4'(FRAME_LEN) - w_n);
  assign w_data    = {bus.EIGHT & w_aligned[7], w_aligned[6:0]};
  assign w_par_bit = bus.EIGHT ? w_aligned[8] : w_aligned[7];
  assign w_stop    = w_aligned[w_n - 4'd1];
  assign w_perr    = bus.PEN & ((^w_data ^ w_par_bit) != bus.OHEL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxrdy <= 1'b0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_done) begin
      r_data  <= w_data;
      r_perr  <= w_perr;
      r_ferr  <= ~w_stop;
      r_rxrdy <= 1'b1;
      if (bus.READS)    r_ovf <= 1'b0;
      else if (r_rxrdy) r_ovf <= 1'b1;
    end else if (bus.READS) begin
      r_rxrdy <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  assign bus.RXRDY     = r_rxrdy;
  assign bus.UART_DATA = r_data;
  assign bus.PERR      = r_perr;
  assign bus.FERR      = r_ferr;
  assign bus.OVF       = r_ovf;
  assign o_state       = r_state;

endmodule
